vga_timing_gen_param: RTL and testbench

- Parametrised successor of the team's fixed 640x480 VGA controller.
- Generates HS/VS/BLANK timing from a single clock, gated by a pixel clock enable.
- Issues a pixel request with coordinates a configurable number of cycles ahead, then aligns the returned host RGB with the sync signals through a matched pipeline.
- Sits between the frame/sprite renderers and the DAC pins.

---
 rtl/vga_timing_gen_param.sv | 261 ++++++++++++++++++++++++++
 tb/tb_vga_timing_gen_param.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_param.sv
// vga_timing_gen_param: parametrised VGA HS/VS/BLANK generator with a pixel request issued
// REQ_LEAD enabled cycles ahead. Define VGA_TEST_PATTERN_EN to output 8 vertical colour bars instead of host RGB.
module vga_timing_gen_param #(
  parameter int COLOR_W  = 10,
  parameter int CNT_W    = 12,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACT    = 640,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACT    = 480,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int REQ_LEAD = 1
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iEN,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic               oRequest,
  output logic [CNT_W-1:0]   oCurrent_X,
  output logic [CNT_W-1:0]   oCurrent_Y,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_HS,
  output logic               oVGA_VS,
  output logic               oVGA_BLANK,
  output logic               oVGA_SYNC,
  output logic               oFrame_Start,
  output logic               oLine_Start
);

  localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
  localparam int H_TOTAL = H_BLANK + H_ACT;
  localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
  localparam int V_TOTAL = V_BLANK + V_ACT;

  localparam logic [CNT_W-1:0] H_LAST_C  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST_C  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_BLANK_C = CNT_W'(H_BLANK);
  localparam logic [CNT_W-1:0] V_BLANK_C = CNT_W'(V_BLANK);
  localparam logic [CNT_W-1:0] HS_BEG_C  = CNT_W'(H_FRONT);
  localparam logic [CNT_W-1:0] HS_END_C  = CNT_W'(H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG_C  = CNT_W'(V_FRONT);
  localparam logic [CNT_W-1:0] VS_END_C  = CNT_W'(V_FRONT + V_SYNC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [COLOR_W-1:0] PIX_ZERO = {COLOR_W{1'b0}};
  localparam logic HS_ON = (HS_POL != 0) ? 1'b1 : 1'b0;
  localparam logic VS_ON = (VS_POL != 0) ? 1'b1 : 1'b0;

  if ((REQ_LEAD < 1) || (REQ_LEAD > 4)) begin : gBadLead
    $error("vga_timing_gen_param: REQ_LEAD=%0d is outside 1..4", REQ_LEAD);
  end

  logic [CNT_W-1:0]   hCont_r;
  logic [CNT_W-1:0]   vCont_r;
  logic               hWrap_s;
  logic               vWrap_s;
  logic               request_s;
  logic               hsRaw_s;
  logic               vsRaw_s;
  logic [CNT_W-1:0]   curX_s;
  logic [CNT_W-1:0]   curY_s;
  // tap bit 2 = data enable, bit 1 = hsync, bit 0 = vsync
  logic [2:0]         tapPipe_r [REQ_LEAD];
  logic               deLate_s;
  logic               hsLate_s;
  logic               vsLate_s;
  logic [COLOR_W-1:0] pixR_s;
  logic [COLOR_W-1:0] pixG_s;
  logic [COLOR_W-1:0] pixB_s;
  logic [COLOR_W-1:0] red_r;
  logic [COLOR_W-1:0] green_r;
  logic [COLOR_W-1:0] blue_r;
  logic               hs_r;
  logic               vs_r;
  logic               blank_r;
  logic               lineStart_r;
  logic               frameStart_r;

  // Position decode: wraps, request window, sync windows, active coordinates
  always_comb begin
    hWrap_s   = (hCont_r == H_LAST_C);
    vWrap_s   = (vCont_r == V_LAST_C);
    request_s = (hCont_r >= H_BLANK_C) && (vCont_r >= V_BLANK_C);
    hsRaw_s   = (hCont_r >= HS_BEG_C) && (hCont_r <= HS_END_C);
    vsRaw_s   = (vCont_r >= VS_BEG_C) && (vCont_r <= VS_END_C);
    if (request_s) begin
      curX_s = hCont_r - H_BLANK_C;
      curY_s = vCont_r - V_BLANK_C;
    end else begin
      curX_s = CNT_ZERO;
      curY_s = CNT_ZERO;
    end
  end

  // Horizontal and vertical position counters
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      hCont_r <= CNT_ZERO;
      vCont_r <= CNT_ZERO;
    end else if (iEN) begin
      if (hWrap_s) begin
        hCont_r <= CNT_ZERO;
        if (vWrap_s) begin
          vCont_r <= CNT_ZERO;
        end else begin
          vCont_r <= vCont_r + CNT_ONE;
        end
      end else begin
        hCont_r <= hCont_r + CNT_ONE;
      end
    end
  end

  // Delay line matching the host's request-to-data latency
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < REQ_LEAD; i++) begin
        tapPipe_r[i] <= 3'b000;
      end
    end else if (iEN) begin
      tapPipe_r[0] <= {request_s, hsRaw_s, vsRaw_s};
      for (int i = 1; i < REQ_LEAD; i++) begin
        tapPipe_r[i] <= tapPipe_r[i-1];
      end
    end
  end

  assign deLate_s = tapPipe_r[REQ_LEAD-1][2];
  assign hsLate_s = tapPipe_r[REQ_LEAD-1][1];
  assign vsLate_s = tapPipe_r[REQ_LEAD-1][0];

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACT / 8;
  localparam logic [CNT_W-1:0] BAR_W_C    = CNT_W'(BAR_W);
  localparam logic [CNT_W-1:0] BAR_LAST_C = CNT_W'(7);

  if (BAR_W < 1) begin : gBadBar
    $error("vga_timing_gen_param: H_ACT=%0d too small for 8 bars", H_ACT);
  end

  logic [CNT_W-1:0] xPipe_r [REQ_LEAD];
  logic [CNT_W-1:0] barNum_s;
  logic [2:0]       barIdx_s;
  logic [2:0]       barRgb_s;
  logic             unusedHost_s;

  // {R,G,B} on/off for each bar, white first, black last
  function automatic logic [2:0] barColor(input logic [2:0] idx);
    case (idx)
      3'd0:    barColor = 3'b111;
      3'd1:    barColor = 3'b110;
      3'd2:    barColor = 3'b011;
      3'd3:    barColor = 3'b010;
      3'd4:    barColor = 3'b101;
      3'd5:    barColor = 3'b100;
      3'd6:    barColor = 3'b001;
      default: barColor = 3'b000;
    endcase
  endfunction

  // X coordinate delayed alongside the sync taps so bars line up with BLANK
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < REQ_LEAD; i++) begin
        xPipe_r[i] <= CNT_ZERO;
      end
    end else if (iEN) begin
      xPipe_r[0] <= curX_s;
      for (int i = 1; i < REQ_LEAD; i++) begin
        xPipe_r[i] <= xPipe_r[i-1];
      end
    end
  end

  // Bar colour for the delayed column
  always_comb begin
    unusedHost_s = ^{iRed, iGreen, iBlue};
    barNum_s     = xPipe_r[REQ_LEAD-1] / BAR_W_C;
    if (barNum_s > BAR_LAST_C) begin
      barIdx_s = 3'd7;
    end else begin
      barIdx_s = barNum_s[2:0];
    end
    barRgb_s = barColor(barIdx_s);
    if (deLate_s) begin
      pixR_s = {COLOR_W{barRgb_s[2]}};
      pixG_s = {COLOR_W{barRgb_s[1]}};
      pixB_s = {COLOR_W{barRgb_s[0]}};
    end else begin
      pixR_s = PIX_ZERO;
      pixG_s = PIX_ZERO;
      pixB_s = PIX_ZERO;
    end
  end
`else
  // Host pixel, forced black outside active video
  always_comb begin
    if (deLate_s) begin
      pixR_s = iRed;
      pixG_s = iGreen;
      pixB_s = iBlue;
    end else begin
      pixR_s = PIX_ZERO;
      pixG_s = PIX_ZERO;
      pixB_s = PIX_ZERO;
    end
  end
`endif

  // Output register: colour, sync polarity and blank
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      red_r   <= PIX_ZERO;
      green_r <= PIX_ZERO;
      blue_r  <= PIX_ZERO;
      hs_r    <= ~HS_ON;
      vs_r    <= ~VS_ON;
      blank_r <= 1'b0;
    end else if (iEN) begin
      red_r   <= pixR_s;
      green_r <= pixG_s;
      blue_r  <= pixB_s;
      hs_r    <= hsLate_s ? HS_ON : ~HS_ON;
      vs_r    <= vsLate_s ? VS_ON : ~VS_ON;
      blank_r <= deLate_s;
    end
  end

  // Wrap pulses: one iCLK wide even when iEN stays low afterwards
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      lineStart_r  <= 1'b0;
      frameStart_r <= 1'b0;
    end else begin
      lineStart_r  <= iEN && hWrap_s;
      frameStart_r <= iEN && hWrap_s && vWrap_s;
    end
  end

  assign oRequest     = request_s;
  assign oCurrent_X   = curX_s;
  assign oCurrent_Y   = curY_s;
  assign oVGA_R       = red_r;
  assign oVGA_G       = green_r;
  assign oVGA_B       = blue_r;
  assign oVGA_HS      = hs_r;
  assign oVGA_VS      = vs_r;
  assign oVGA_BLANK   = blank_r;
  assign oVGA_SYNC    = 1'b1;
  assign oLine_Start  = lineStart_r;
  assign oFrame_Start = frameStart_r;

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// Directed bench for vga_timing_gen_param using shrunk timings (23x7 and 15x5 frames) so whole frames stay short.
module tb_vga_timing_gen_param;

  localparam int CW = 10;
  localparam int NW = 12;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic          iEN;
  logic [CW-1:0] iRed, iGreen, iBlue, zeroIn;

  logic          oRequest, oVGA_HS, oVGA_VS, oVGA_BLANK, oVGA_SYNC, oFrame_Start, oLine_Start;
  logic [NW-1:0] oCurrent_X, oCurrent_Y;
  logic [CW-1:0] oVGA_R, oVGA_G, oVGA_B;

  logic          req2, hs2, vs2, blank2, sync2, fs2, ls2;
  logic [NW-1:0] x2, y2;
  logic [CW-1:0] r2, g2, b2;

  always #5 iCLK = ~iCLK;

  vga_timing_gen_param #(
    .COLOR_W(CW), .CNT_W(NW),
    .H_FRONT(2), .H_SYNC(3), .H_BACK(2), .H_ACT(16),
    .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .V_ACT(3),
    .HS_POL(0), .VS_POL(0), .REQ_LEAD(2)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iEN(iEN),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .oRequest(oRequest), .oCurrent_X(oCurrent_X), .oCurrent_Y(oCurrent_Y),
    .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
    .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS), .oVGA_BLANK(oVGA_BLANK), .oVGA_SYNC(oVGA_SYNC),
    .oFrame_Start(oFrame_Start), .oLine_Start(oLine_Start)
  );

  vga_timing_gen_param #(
    .COLOR_W(CW), .CNT_W(NW),
    .H_FRONT(1), .H_SYNC(4), .H_BACK(2), .H_ACT(8),
    .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .V_ACT(2),
    .HS_POL(1), .VS_POL(1), .REQ_LEAD(1)
  ) dut2 (
    .iCLK(iCLK), .iRST(iRST), .iEN(iEN),
    .iRed(zeroIn), .iGreen(zeroIn), .iBlue(zeroIn),
    .oRequest(req2), .oCurrent_X(x2), .oCurrent_Y(y2),
    .oVGA_R(r2), .oVGA_G(g2), .oVGA_B(b2),
    .oVGA_HS(hs2), .oVGA_VS(vs2), .oVGA_BLANK(blank2), .oVGA_SYNC(sync2),
    .oFrame_Start(fs2), .oLine_Start(ls2)
  );

  typedef struct {
    int   cyc;
    logic req;   int x; int y;
    logic blank; logic hs; logic vs; int r; int g;
    logic ls;    logic fs;
    logic chk2;  logic hs2; logic vs2; logic blank2;
  } vec_t;

  vec_t          vecs[$];
  int            tests = 0;
  int            fails = 0;
  int            n = 0;
  logic [NW-1:0] xd1, xd2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // host model: iRed follows oCurrent_X two enabled cycles late
  task automatic feed();
    iRed = xd2[CW-1:0];
    xd2  = xd1;
    xd1  = oCurrent_X;
  endtask

  task automatic stepEn();
    @(posedge iCLK);
    n++;
    @(negedge iCLK);
    feed();
  endtask

  task automatic doReset();
    iRST = 1'b1;
    iEN  = 1'b1;
    iRed = '0;
    xd1  = '0;
    xd2  = '0;
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    n    = 0;
    feed();
  endtask

  initial begin
    int hsLow, vsLow, lsCnt, fsCnt, cnt, run, maxRun;
    string tag;
    iRST = 1'b1; iEN = 1'b1; iRed = '0; iGreen = 10'h155; iBlue = 10'h000; zeroIn = 10'h000;

    //               cyc  req x   y  bl hs vs r   g      ls fs c2 hs2 vs2 bl2
    vecs.push_back('{  0, 0,  0,  0, 0, 1, 1, 0,  0,     0, 0, 1, 0,  0,  0});
    vecs.push_back('{  5, 0,  0,  0, 0, 0, 1, 0,  0,     0, 0, 1, 1,  0,  0});
    vecs.push_back('{  7, 0,  0,  0, 0, 0, 1, 0,  0,     0, 0, 1, 0,  0,  0});
    vecs.push_back('{  8, 0,  0,  0, 0, 1, 1, 0,  0,     0, 0, 0, 0,  0,  0});
    vecs.push_back('{ 23, 0,  0,  0, 0, 1, 1, 0,  0,     1, 0, 1, 0,  1,  0});
    vecs.push_back('{ 24, 0,  0,  0, 0, 1, 1, 0,  0,     0, 0, 0, 0,  0,  0});
    vecs.push_back('{ 26, 0,  0,  0, 0, 1, 0, 0,  0,     0, 0, 0, 0,  0,  0});
    vecs.push_back('{ 53, 0,  0,  0, 0, 0, 0, 0,  0,     0, 0, 1, 0,  0,  0});
    vecs.push_back('{ 54, 0,  0,  0, 0, 1, 0, 0,  0,     0, 0, 1, 0,  0,  1});
    vecs.push_back('{ 69, 0,  0,  0, 0, 1, 0, 0,  0,     1, 0, 0, 0,  0,  0});
    vecs.push_back('{ 72, 0,  0,  0, 0, 1, 1, 0,  0,     0, 0, 0, 0,  0,  0});
    vecs.push_back('{ 99, 1,  0,  0, 0, 0, 1, 0,  0,     0, 0, 0, 0,  0,  0});
    vecs.push_back('{102, 1,  3,  0, 1, 1, 1, 0,  'h155, 0, 0, 0, 0,  0,  0});
    vecs.push_back('{105, 1,  6,  0, 1, 1, 1, 3,  'h155, 0, 0, 0, 0,  0,  0});
    vecs.push_back('{114, 1, 15,  0, 1, 1, 1, 12, 'h155, 0, 0, 0, 0,  0,  0});
    vecs.push_back('{115, 0,  0,  0, 1, 1, 1, 13, 'h155, 1, 0, 0, 0,  0,  0});
    vecs.push_back('{117, 0,  0,  0, 1, 1, 1, 15, 'h155, 0, 0, 0, 0,  0,  0});
    vecs.push_back('{118, 0,  0,  0, 0, 1, 1, 0,  0,     0, 0, 0, 0,  0,  0});
    vecs.push_back('{124, 1,  2,  1, 0, 1, 1, 0,  0,     0, 0, 0, 0,  0,  0});
    vecs.push_back('{160, 1, 15,  2, 1, 1, 1, 12, 'h155, 0, 0, 0, 0,  0,  0});
    vecs.push_back('{161, 0,  0,  0, 1, 1, 1, 13, 'h155, 1, 1, 0, 0,  0,  0});
    vecs.push_back('{162, 0,  0,  0, 1, 1, 1, 14, 'h155, 0, 0, 0, 0,  0,  0});
    vecs.push_back('{163, 0,  0,  0, 1, 1, 1, 15, 'h155, 0, 0, 0, 0,  0,  0});
    vecs.push_back('{164, 0,  0,  0, 0, 1, 1, 0,  0,     0, 0, 0, 0,  0,  0});
    vecs.push_back('{322, 0,  0,  0, 1, 1, 1, 13, 'h155, 1, 1, 0, 0,  0,  0});

    doReset();
    for (int i = 0; i < vecs.size(); i++) begin
      while (n < vecs[i].cyc) stepEn();
      tag = $sformatf("c%0d", vecs[i].cyc);
      check({tag, "_req"},   oRequest,     vecs[i].req);
      check({tag, "_x"},     oCurrent_X,   vecs[i].x);
      check({tag, "_y"},     oCurrent_Y,   vecs[i].y);
      check({tag, "_blank"}, oVGA_BLANK,   vecs[i].blank);
      check({tag, "_hs"},    oVGA_HS,      vecs[i].hs);
      check({tag, "_vs"},    oVGA_VS,      vecs[i].vs);
      check({tag, "_r"},     oVGA_R,       vecs[i].r);
      check({tag, "_g"},     oVGA_G,       vecs[i].g);
      check({tag, "_b"},     oVGA_B,       0);
      check({tag, "_sync"},  oVGA_SYNC,    1);
      check({tag, "_ls"},    oLine_Start,  vecs[i].ls);
      check({tag, "_fs"},    oFrame_Start, vecs[i].fs);
      if (vecs[i].chk2) begin
        check({tag, "_hs2"},    hs2,    vecs[i].hs2);
        check({tag, "_vs2"},    vs2,    vecs[i].vs2);
        check({tag, "_blank2"}, blank2, vecs[i].blank2);
      end
    end

    // one full frame of the 23x7 instance
    hsLow = 0; vsLow = 0; lsCnt = 0; fsCnt = 0;
    for (int k = 0; k < 161; k++) begin
      stepEn();
      if (!oVGA_HS) hsLow++;
      if (!oVGA_VS) vsLow++;
      if (oLine_Start) lsCnt++;
      if (oFrame_Start) fsCnt++;
    end
    check("frame_hs_low", hsLow, 21);
    check("frame_vs_low", vsLow, 46);
    check("frame_ls_cnt", lsCnt, 7);
    check("frame_fs_cnt", fsCnt, 1);

    // one full frame of the positive-polarity 15x5 instance
    hsLow = 0; vsLow = 0; fsCnt = 0;
    for (int k = 0; k < 75; k++) begin
      stepEn();
      if (hs2) hsLow++;
      if (vs2) vsLow++;
      if (fs2) fsCnt++;
    end
    check("pol_hs_high", hsLow, 20);
    check("pol_vs_high", vsLow, 15);
    check("pol_fs_cnt",  fsCnt, 1);

    // frame start period
    cnt = 0;
    while (!oFrame_Start && cnt < 200) begin stepEn(); cnt++; end
    check("fs_seen", oFrame_Start, 1);
    cnt = 0;
    do begin stepEn(); cnt++; end while (!oFrame_Start && cnt < 400);
    check("fs_period", cnt, 161);

    // iEN toggling: two lines span 92 iCLKs
    hsLow = 0; lsCnt = 0; run = 0; maxRun = 0;
    for (int k = 0; k < 96; k++) begin
      iEN = (k % 2 == 0);
      @(posedge iCLK);
      @(negedge iCLK);
      if (k >= 4) begin
        if (!oVGA_HS) hsLow++;
        if (oLine_Start) begin lsCnt++; run++; end else run = 0;
        if (run > maxRun) maxRun = run;
      end
    end
    iEN = 1'b1;
    check("half_en_hs_low", hsLow, 12);
    check("half_en_ls_cnt", lsCnt, 2);
    check("half_en_ls_width", maxRun, 1);

    // reset mid-frame exactly on the frame-wrap cycle with active video in flight
    doReset();
    while (n < 160) stepEn();
    check("pre_rst_blank", oVGA_BLANK, 1);
    iRST = 1'b1;
    @(posedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    n = 0; xd1 = '0; xd2 = '0;
    feed();
    check("rst_req",    oRequest,     0);
    check("rst_x",      oCurrent_X,   0);
    check("rst_hs",     oVGA_HS,      1);
    check("rst_vs",     oVGA_VS,      1);
    check("rst_blank",  oVGA_BLANK,   0);
    check("rst_r",      oVGA_R,       0);
    check("rst_ls",     oLine_Start,  0);
    check("rst_fs",     oFrame_Start, 0);
    check("rst_hs2",    hs2,          0);
    check("rst_blank2", blank2,       0);
    cnt = 0;
    while (!oFrame_Start && cnt < 400) begin stepEn(); cnt++; end
    check("rst_first_fs", cnt, 161);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
